// File: rtl/pll_cen_gen.sv
// pll_cen_gen: multi-channel fractional num/den clock-enable generator with lock/settle handshake.
// Define PLL_CEN_PHASE_EN to add the cfg_phase port and per-channel start-phase skew.
module pll_cen_gen #(
    parameter int CHANNELS    = 2,
    parameter int ACC_W       = 16,
    parameter int LOCK_CYCLES = 1024,
    parameter int DEF_NUM     = 11,
    parameter int DEF_DEN     = 50,
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1,
    localparam int LW = $clog2(LOCK_CYCLES + 1)
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CW-1:0]       cfg_chan,
    input  logic [ACC_W-1:0]    cfg_num,
    input  logic [ACC_W-1:0]    cfg_den,
`ifdef PLL_CEN_PHASE_EN
    input  logic [ACC_W-1:0]    cfg_phase,
`endif
    output logic [CHANNELS-1:0] cen,
    output logic                locked
);
    typedef enum logic {SETTLE, LOCKED} state_t;
    state_t state;
    logic [LW-1:0] cnt;
    logic [ACC_W-1:0] num [CHANNELS];
    logic [ACC_W-1:0] den [CHANNELS];
    logic [ACC_W-1:0] acc [CHANNELS];
    logic [ACC_W-1:0] num_eff [CHANNELS];
    logic [ACC_W-1:0] acc_nxt [CHANNELS];
    logic [ACC_W-1:0] start [CHANNELS];
    logic [ACC_W:0] sum [CHANNELS];
    logic [CHANNELS-1:0] hit;
    logic accept;
`ifdef PLL_CEN_PHASE_EN
    logic [ACC_W-1:0] phase [CHANNELS];
`endif
    assign accept = cfg_valid && cfg_ready;
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            num_eff[i] = num[i] < den[i] ? num[i] : den[i];
            sum[i] = {1'b0, acc[i]} + {1'b0, num_eff[i]};
            hit[i] = den[i] != '0 && sum[i] >= {1'b0, den[i]};
            acc_nxt[i] = den[i] == '0 ? '0 : hit[i] ? ACC_W'(sum[i] - {1'b0, den[i]}) : sum[i][ACC_W-1:0];
`ifdef PLL_CEN_PHASE_EN
            start[i] = den[i] == '0 ? '0 : phase[i] < den[i] ? phase[i] : den[i] - ACC_W'(1);
`else
            start[i] = '0;
`endif
        end
    end
    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= SETTLE;
            cnt       <= '0;
            locked    <= 1'b0;
            cfg_ready <= 1'b0;
            cen       <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                num[i] <= ACC_W'(DEF_NUM);
                den[i] <= ACC_W'(DEF_DEN);
                acc[i] <= '0;
`ifdef PLL_CEN_PHASE_EN
                phase[i] <= '0;
`endif
            end
        end else if (state == SETTLE) begin
            cnt <= cnt + 1'b1;
            if (cnt == LW'(LOCK_CYCLES - 1)) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                cfg_ready <= 1'b1;
                for (int i = 0; i < CHANNELS; i++) acc[i] <= start[i];
            end
        end else if (accept) begin
            // every channel re-settles so all restart phase-aligned at the next lock
            state     <= SETTLE;
            cnt       <= '0;
            locked    <= 1'b0;
            cfg_ready <= 1'b0;
            cen       <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                if (cfg_chan == CW'(i)) begin
                    num[i] <= cfg_num;
                    den[i] <= cfg_den;
`ifdef PLL_CEN_PHASE_EN
                    phase[i] <= cfg_phase;
`endif
                end
            end
        end else begin
            cen <= hit;
            for (int i = 0; i < CHANNELS; i++) acc[i] <= acc_nxt[i];
        end
    end
endmodule

// File: tb/tb_pll_cen_gen.sv
// tb_pll_cen_gen: directed self-checking bench for pll_cen_gen (3 channels, 16-cycle lock).
module tb_pll_cen_gen;
    localparam int CH = 3;
    localparam int W  = 16;
    logic refclk = 1'b0, rst = 1'b1, cfg_valid = 1'b0;
    logic cfg_ready, locked;
    logic [1:0] cfg_chan = '0;
    logic [W-1:0] cfg_num = '0, cfg_den = '0;
`ifdef PLL_CEN_PHASE_EN
    logic [W-1:0] cfg_phase = '0;
`endif
    logic [CH-1:0] cen;
    int checks = 0, errors = 0;
    int pcnt [CH];
    int pfirst [CH];
    logic [CH-1:0] hist [200];
    logic lost;
    int n;
    logic seen;

    pll_cen_gen #(.CHANNELS(CH), .ACC_W(W), .LOCK_CYCLES(16), .DEF_NUM(11), .DEF_DEN(50)) dut (
        .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan), .cfg_num(cfg_num), .cfg_den(cfg_den),
`ifdef PLL_CEN_PHASE_EN
        .cfg_phase(cfg_phase),
`endif
        .cen(cen), .locked(locked)
    );

    always #5 refclk = ~refclk;

    task automatic tick;
        @(posedge refclk);
        #1;
    endtask

    task automatic settle(output int k, output logic s);
        k = 0;
        s = 1'b0;
        while (!locked && k < 100) begin
            tick;
            k++;
            if (!locked) s = s | (|cen) | cfg_ready;
        end
    endtask

    task automatic run(input int cycles);
        lost = 1'b0;
        for (int c = 0; c < CH; c++) begin
            pcnt[c] = 0;
            pfirst[c] = 0;
        end
        for (int k = 0; k < cycles; k++) begin
            tick;
            if (!locked) lost = 1'b1;
            if (k < 200) hist[k] = cen;
            for (int c = 0; c < CH; c++) begin
                if (cen[c]) begin
                    pcnt[c]++;
                    if (pfirst[c] == 0) pfirst[c] = k + 1;
                end
            end
        end
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [W-1:0] nm, input logic [W-1:0] dn);
        int w = 0;
        cfg_chan = ch;
        cfg_num = nm;
        cfg_den = dn;
        cfg_valid = 1'b1;
        while (!cfg_ready && w < 100) begin
            tick;
            w++;
        end
        tick;
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        checks++;
        if ({locked, cfg_ready, cen} !== '0) begin
            errors++;
            $display("FAIL reset_state: got %b want 0", {locked, cfg_ready, cen});
        end
        rst = 1'b0;
        settle(n, seen);
        checks++;
        if (n !== 16) begin errors++; $display("FAIL reset_lock_edge: got %0d want 16", n); end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL reset_settle_quiet: got %b want 0", seen); end
        checks++;
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
        run(5000);
        for (int c = 0; c < CH; c++) begin
            checks++;
            if (pfirst[c] !== 5) begin errors++; $display("FAIL reset_first_cen ch%0d: got %0d want 5", c, pfirst[c]); end
            checks++;
            if (pcnt[c] !== 1100) begin errors++; $display("FAIL reset_rate ch%0d: got %0d want 1100", c, pcnt[c]); end
        end
    endtask

    task automatic test_reconfig;
        int bad = 0;
        cfg_write(2'd1, 16'd1, 16'd2);
        checks++;
        if ({locked, cfg_ready, cen} !== '0) begin
            errors++;
            $display("FAIL reconfig_drop: got %b want 0", {locked, cfg_ready, cen});
        end
        settle(n, seen);
        checks++;
        if (n !== 16) begin errors++; $display("FAIL reconfig_relock: got %0d want 16", n); end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL reconfig_settle_quiet: got %b want 0", seen); end
        run(100);
        for (int k = 0; k < 100; k++) if (hist[k][1] !== (k % 2 == 1)) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL reconfig_ch1_alternate: got %0d bad cycles want 0", bad); end
        checks++;
        if (pfirst[0] !== 5 || pcnt[0] !== 22) begin
            errors++;
            $display("FAIL reconfig_ch0: got first %0d count %0d want 5 22", pfirst[0], pcnt[0]);
        end
        checks++;
        if (pfirst[1] !== 2 || pcnt[1] !== 50) begin
            errors++;
            $display("FAIL reconfig_ch1: got first %0d count %0d want 2 50", pfirst[1], pcnt[1]);
        end
    endtask

    task automatic test_edge_ratios;
        cfg_write(2'd0, 16'd0, 16'd50);
        settle(n, seen);
        cfg_write(2'd1, 16'd7, 16'd5);
        settle(n, seen);
        cfg_write(2'd2, 16'd5, 16'd0);
        settle(n, seen);
        checks++;
        if (n !== 16) begin errors++; $display("FAIL edge_relock: got %0d want 16", n); end
        run(100);
        checks++;
        if (pcnt[0] !== 0) begin errors++; $display("FAIL edge_num0: got %0d want 0", pcnt[0]); end
        checks++;
        if (pcnt[1] !== 100) begin errors++; $display("FAIL edge_num_ge_den: got %0d want 100", pcnt[1]); end
        checks++;
        if (pcnt[2] !== 0) begin errors++; $display("FAIL edge_den0: got %0d want 0", pcnt[2]); end
    endtask

    task automatic test_back_to_back;
        cfg_write(2'd2, 16'd11, 16'd50);
        cfg_chan = 2'd0;
        cfg_num = 16'd3;
        cfg_den = 16'd4;
        cfg_valid = 1'b1;
        settle(n, seen);
        checks++;
        if (n !== 16 || seen !== 1'b0) begin
            errors++;
            $display("FAIL held_valid_settle: got %0d/%b want 16/0", n, seen);
        end
        tick;
        cfg_valid = 1'b0;
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL held_valid_accept: got %b want 0", locked); end
        settle(n, seen);
        checks++;
        if (n !== 16) begin errors++; $display("FAIL held_valid_relock: got %0d want 16", n); end
        run(100);
        checks++;
        if (lost !== 1'b0) begin errors++; $display("FAIL held_valid_once: got %b want 0", lost); end
        checks++;
        if (pcnt[0] !== 75 || pfirst[0] !== 2) begin
            errors++;
            $display("FAIL held_valid_ch0: got count %0d first %0d want 75 2", pcnt[0], pfirst[0]);
        end
        checks++;
        if (pcnt[2] !== 22) begin errors++; $display("FAIL held_valid_ch2: got %0d want 22", pcnt[2]); end
    endtask

    task automatic test_bad_chan;
        cfg_write(2'd3, 16'd1, 16'd1);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL bad_chan_accept: got %b want 0", locked); end
        settle(n, seen);
        checks++;
        if (n !== 16) begin errors++; $display("FAIL bad_chan_relock: got %0d want 16", n); end
        run(100);
        checks++;
        if (pcnt[0] !== 75 || pcnt[1] !== 100 || pcnt[2] !== 22) begin
            errors++;
            $display("FAIL bad_chan_regs: got %0d %0d %0d want 75 100 22", pcnt[0], pcnt[1], pcnt[2]);
        end
    endtask

    task automatic test_rst_override;
        cfg_chan = 2'd0;
        cfg_num = 16'd1;
        cfg_den = 16'd1;
        cfg_valid = 1'b1;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        cfg_valid = 1'b0;
        checks++;
        if ({locked, cfg_ready, cen} !== '0) begin
            errors++;
            $display("FAIL rst_handshake_state: got %b want 0", {locked, cfg_ready, cen});
        end
        repeat (5) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        settle(n, seen);
        checks++;
        if (n !== 16) begin errors++; $display("FAIL rst_mid_settle: got %0d want 16", n); end
        run(100);
        for (int c = 0; c < CH; c++) begin
            checks++;
            if (pcnt[c] !== 22 || pfirst[c] !== 5) begin
                errors++;
                $display("FAIL rst_defaults ch%0d: got count %0d first %0d want 22 5", c, pcnt[c], pfirst[c]);
            end
        end
    endtask

`ifdef PLL_CEN_PHASE_EN
    task automatic test_phase;
        cfg_phase = 16'd25;
        cfg_write(2'd1, 16'd11, 16'd50);
        cfg_phase = 16'd0;
        settle(n, seen);
        run(100);
        checks++;
        if (pfirst[1] !== 3 || pfirst[0] !== 5) begin
            errors++;
            $display("FAIL phase_first: got ch1 %0d ch0 %0d want 3 5", pfirst[1], pfirst[0]);
        end
        checks++;
        if (pcnt[1] !== 22) begin errors++; $display("FAIL phase_rate: got %0d want 22", pcnt[1]); end
    endtask
`endif

    initial begin
        test_reset;
        test_reconfig;
        test_edge_ratios;
        test_back_to_back;
        test_bad_chan;
        test_rst_override;
`ifdef PLL_CEN_PHASE_EN
        test_phase;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
